// File: rtl/inst_fetch_buffer_pkg.sv
// Shared fetch/decode definitions: canonical NOP,
// instruction field bit ranges, queue entry layout.
package inst_fetch_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam int OP_LO  = 0;
  localparam int OP_HI  = 6;
  localparam int RD_LO  = 7;
  localparam int RD_HI  = 11;
  localparam int FN3_LO = 12;
  localparam int FN3_HI = 14;
  localparam int RS1_LO = 15;
  localparam int RS1_HI = 19;
  localparam int RS2_LO = 20;
  localparam int RS2_HI = 24;
  localparam int FN7_LO = 25;
  localparam int FN7_HI = 31;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_mem.sv
// fetch_buf_mem: DEPTH x 64-bit register array,
// one write port, one async read port, no reset.
module fetch_buf_mem
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      we,
  input  logic [PW-1:0] waddr,
  input  fb_entry_t wdata,
  input  logic [PW-1:0] raddr,
  output fb_entry_t rdata
);

  fb_entry_t mem [DEPTH];

  // Write port; contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// Fetch-to-decode queue with flush and NOP head.
// Optional same-cycle bypass: INST_FETCH_BUF_BYPASS_EN.
module inst_fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR =
    inst_fetch_buffer_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop_en,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [6:0]  out_op,
  output logic [2:0]  out_fn3,
  output logic [6:0]  out_fn7,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [$clog2(DEPTH):0] count
);

  import inst_fetch_buffer_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;

  fb_entry_t wr_data;
  fb_entry_t rd_data;
  fb_entry_t head;

  logic stored;
  logic byp;
  logic push;
  logic pop;
  logic byp_take;
  logic do_wr;
  logic do_rd;
  logic mem_we;

  assign stored     = cnt_q != '0;
  assign push_ready = cnt_q != CW'(DEPTH);

`ifdef INST_FETCH_BUF_BYPASS_EN
  assign byp = ~stored & push_valid;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = stored | byp;
  assign push      = push_valid & push_ready;
  assign pop       = pop_en & out_valid;
  // A bypassed entry consumed at once is never stored
  assign byp_take  = byp & pop_en;
  assign do_wr     = push & ~byp_take;
  assign do_rd     = pop & ~byp_take;
  assign mem_we    = do_wr & ~flush & ~rst;

  assign wr_data.pc    = push_pc;
  assign wr_data.instr = push_instr;

  fetch_buf_mem #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Head select: bypass, stored entry, or NOP
  always_comb begin
    head.pc    = '0;
    head.instr = NOP_INSTR;
    if (byp) begin
      head = wr_data;
    end else if (stored) begin
      head = rd_data;
    end
  end

  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_op    = out_instr[OP_HI:OP_LO];
  assign out_fn3   = out_instr[FN3_HI:FN3_LO];
  assign out_fn7   = out_instr[FN7_HI:FN7_LO];
  assign out_rs1   = out_instr[RS1_HI:RS1_LO];
  assign out_rs2   = out_instr[RS2_HI:RS2_LO];
  assign out_rd    = out_instr[RD_HI:RD_LO];
  assign count     = cnt_q;

  // Pointer/occupancy control: rst > flush > push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        do_wr & ~do_rd: cnt_q <= cnt_q + CW'(1);
        do_rd & ~do_wr: cnt_q <= cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer; honours
// INST_FETCH_BUF_BYPASS_EN when defined.
module tb_inst_fetch_buffer;
  import inst_fetch_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic        pop_en;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [6:0]  out_op;
  logic [2:0]  out_fn3;
  logic [6:0]  out_fn7;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  logic [63:0] sb_q [$];
  logic [31:0] npc;

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_pc    (push_pc),
    .push_instr (push_instr),
    .pop_en     (pop_en),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .out_op     (out_op),
    .out_fn3    (out_fn3),
    .out_fn7    (out_fn7),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .count      (count)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle; queue the entry if the queue takes it
  task automatic cyc(bit pv, logic [31:0] pc,
                     logic [31:0] ins, bit pe,
                     bit fl, bit r);
    bit acc;
    rst = r;
    flush = fl;
    push_valid = pv;
    push_pc = pc;
    push_instr = ins;
    pop_en = pe;
    acc = !r && !fl && pv && (sb_q.size() < DEPTH);
`ifdef INST_FETCH_BUF_BYPASS_EN
    if (sb_q.size() == 0 && pe) acc = 1'b0;
`endif
    @(posedge clk);
    if (acc) sb_q.push_back({pc, ins});
    #1;
  endtask

  task automatic idle_neg();
    rst = 0;
    flush = 0;
    push_valid = 0;
    pop_en = 0;
    @(negedge clk);
  endtask

  task automatic back();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare head/occupancy, retire consumed entries
  always @(negedge clk) begin
    logic [31:0] epc;
    logic [31:0] ein;
    bit ev;
    if (mon_en) begin
      ev = sb_q.size() > 0;
      epc = 32'h0;
      ein = 32'h00000013;
      if (ev) begin
        {epc, ein} = sb_q[0];
      end
`ifdef INST_FETCH_BUF_BYPASS_EN
      else if (push_valid) begin
        ev = 1'b1;
        epc = push_pc;
        ein = push_instr;
      end
`endif
      chk("count", 64'(count), 64'(sb_q.size()));
      chk("ready", 64'(push_ready),
          64'(sb_q.size() != DEPTH));
      chk("valid", 64'(out_valid), 64'(ev));
      chk("pc", 64'(out_pc), 64'(epc));
      chk("instr", 64'(out_instr), 64'(ein));
      chk("fields",
          64'({out_fn7, out_rs2, out_rs1,
               out_fn3, out_rd, out_op}),
          64'(ein));
      if (rst || flush) sb_q.delete();
      else if (pop_en && sb_q.size() > 0)
        void'(sb_q.pop_front());
    end
  end

  initial begin
    rst = 1;
    flush = 0;
    push_valid = 1;
    push_pc = 32'h100;
    push_instr = 32'hdeadbeef;
    pop_en = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(1, 32'h104, 32'h12345678, 0, 0, 1);

    idle_neg();
    chk("rst_instr", 64'(out_instr), 64'h13);
    chk("rst_valid", 64'(out_valid), 64'd0);
    back();

    // Fill, overfill, drain in order
    for (int i = 0; i < 5; i++)
      cyc(1, 32'(i * 4), $urandom, 0, 0, 0);
    idle_neg();
    chk("full_cnt", 64'(count), 64'd4);
    chk("full_rdy", 64'(push_ready), 64'd0);
    back();
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 1, 0, 0);

    // Streaming at occupancy 2 across wraps
    npc = 32'h1000;
    for (int i = 0; i < 2; i++) begin
      cyc(1, npc, $urandom, 0, 0, 0);
      npc += 4;
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1, npc, $urandom, 1, 0, 0);
      npc += 4;
    end
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // Flush beats simultaneous push and pop
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h200 + 32'(i * 4), $urandom, 0, 0, 0);
    cyc(1, 32'h2ff, 32'h0, 1, 1, 0);
    idle_neg();
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_op", 64'(out_op), 64'b0010011);
    chk("fl_rd", 64'(out_rd), 64'd0);
    back();

    // Field decode of sub x10,x10,x11
    cyc(1, 32'h300, 32'h40B50533, 0, 0, 0);
    idle_neg();
    chk("sub_op", 64'(out_op), 64'b0110011);
    chk("sub_fn3", 64'(out_fn3), 64'd0);
    chk("sub_fn7", 64'(out_fn7), 64'b0100000);
    chk("sub_rs1", 64'(out_rs1), 64'd10);
    chk("sub_rs2", 64'(out_rs2), 64'd11);
    chk("sub_rd", 64'(out_rd), 64'd10);
    back();
    cyc(0, 0, 0, 1, 0, 0);

    // Push into empty queue with pop_en high
    cyc(1, 32'h40, 32'h00100093, 1, 0, 0);
    idle_neg();
`ifdef INST_FETCH_BUF_BYPASS_EN
    chk("byp_cnt", 64'(count), 64'd0);
`else
    chk("byp_cnt", 64'(count), 64'd1);
`endif
    back();
    cyc(0, 0, 0, 1, 0, 0);

    // Random traffic
    npc = 32'h8000;
    for (int i = 0; i < 600; i++) begin
      bit pv;
      pv = ($urandom_range(0, 9) < 7);
      cyc(pv, npc, $urandom,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 31) == 0,
          $urandom_range(0, 199) == 0);
      if (pv) npc += 4;
    end
    cyc(0, 0, 0, 0, 1, 0);
    idle_neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
